lagarto_reset_sequencer: RTL

Multi-hart reset and wake-up sequencer for Lagarto tiles. After the tile comes out of reset, it holds a global wake-up delay. It then releases each enabled hart's core reset, in a staggered order or all at once. It also services per-hart soft-reset requests with a req/ack handshake. It sits between the tile reset input and the core/CSR reset pins, and generalises the single-core wake-up counter plus synchronizer to NumHarts harts.

---
 rtl/lagarto_reset_sequencer_if.sv | 35 +++
 rtl/lagarto_reset_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_reset_sequencer_if.sv
// Purpose: groups the mask, soft-reset handshake and reset outputs of the Lagarto reset sequencer.
// Latency: none, wires only.
// Backpressure: soft_rst_req_i is a level held by the requester until soft_rst_ack_o pulses.
interface lagarto_reset_sequencer_if #(
  parameter int NumHarts = 4
) ();

  logic [NumHarts-1:0] hart_mask_i;
  logic [NumHarts-1:0] soft_rst_req_i;
  logic [NumHarts-1:0] soft_rst_ack_o;
  logic                spc_grst_l;
  logic [NumHarts-1:0] core_rst_no;
  logic                busy_o;

  // Tile-side controller: drives mask and requests, observes resets and acks.
  modport master (
    output hart_mask_i,
    output soft_rst_req_i,
    input  soft_rst_ack_o,
    input  spc_grst_l,
    input  core_rst_no,
    input  busy_o
  );

  // Sequencer side.
  modport slave (
    input  hart_mask_i,
    input  soft_rst_req_i,
    output soft_rst_ack_o,
    output spc_grst_l,
    output core_rst_no,
    output busy_o
  );

endinterface

// File: rtl/lagarto_reset_sequencer.sv
// Purpose: multi-hart wake-up delay, staggered/simultaneous core reset release and per-hart soft reset.
// Latency: every reset output lags its internal pre-sync value by SyncStages cycles; soft reset acks after SoftRstCycles+SyncStages.
// Backpressure: requests are levels; a request to a hart already in soft reset is absorbed until its ack.
// Optional feature: define LAGARTO_RST_SEQ_STAGGER_EN for one release slot per StaggerCycles;
// without it all enabled harts are released together at the wake-done edge.
module lagarto_reset_sequencer #(
  parameter int NumHarts      = 4,
  parameter int WakeCntWidth  = 16,
  parameter int StaggerCycles = 8,
  parameter int SoftRstCycles = 16,
  parameter int SyncStages    = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_l,
  lagarto_reset_sequencer_if.slave        bus
);

  // Width of the per-hart soft reset counter (counts 1..SoftRstCycles).
  localparam int SoftCntW = $clog2(SoftRstCycles + 1);
  // All reset signals travel through one shared chain; the top bit is the global reset.
  localparam int SigW     = NumHarts + 1;

  if (NumHarts < 1 || NumHarts > 16 || StaggerCycles < 1 || SoftRstCycles < 1 ||
      SyncStages < 1 || WakeCntWidth < 1) begin : g_param_check
    $error("lagarto_reset_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_WAKE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                  state_q, state_d;

  logic [WakeCntWidth-1:0] wake_cnt_q, wake_cnt_d;
  logic                    wake_done;

  logic [NumHarts-1:0]     mask_q, mask_d;
  logic                    grst_pre_q, grst_pre_d;
  logic [NumHarts-1:0]     core_pre_q, core_pre_d;
  logic [NumHarts-1:0]     inflight_q, inflight_d;
  logic [NumHarts-1:0]     ack_q, ack_d;
  logic [SoftCntW-1:0]     soft_cnt_q [NumHarts];
  logic [SoftCntW-1:0]     soft_cnt_d [NumHarts];

  logic [SigW-1:0]         sync_q [SyncStages];
  logic [SigW-1:0]         sync_d [SyncStages];
  logic [SigW-1:0]         pre_vec;
  logic [SigW-1:0]         stage_in_last;
  logic [SigW-1:0]         sync_last;
  logic                    settled;
  logic                    busy;

`ifdef LAGARTO_RST_SEQ_STAGGER_EN
  localparam int PtrW     = (NumHarts > 1) ? $clog2(NumHarts) : 1;
  localparam int StagCntW = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;

  logic [PtrW-1:0]     slot_ptr_q, slot_ptr_d;
  logic [PtrW-1:0]     slot_ptr_nxt;
  logic [StagCntW-1:0] stag_cnt_q, stag_cnt_d;
  logic                slot_adv;
  logic                last_slot;

  // A new slot opens when the current one has lasted StaggerCycles edges.
  assign slot_ptr_nxt = slot_ptr_q + PtrW'(1);
  assign slot_adv     = (stag_cnt_q == StagCntW'(StaggerCycles - 1));
  assign last_slot    = (slot_ptr_nxt == PtrW'(NumHarts - 1));
`endif

  // Wake-up counter: runs only in WAKE and saturates once its MSB is set.
  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if (state_q == ST_WAKE && !wake_cnt_q[WakeCntWidth-1]) begin
      wake_cnt_d = wake_cnt_q + WakeCntWidth'(1);
    end
    wake_done = (state_q == ST_WAKE) && wake_cnt_d[WakeCntWidth-1];
  end

  // FSM next state: WAKE -> RELEASE -> RUN; only reset_l leaves RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAKE: begin
        if (wake_done) begin
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
          // A single hart has no further slots to wait for.
          state_d = (NumHarts == 1) ? ST_RUN : ST_RELEASE;
`else
          state_d = ST_RELEASE;
`endif
        end
      end
      ST_RELEASE: begin
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
        if (slot_adv && last_slot) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_WAKE;
      end
    endcase
  end

  // Pre-sync reset values: global release, hart release slots and per-hart soft resets.
  always_comb begin
    mask_d     = mask_q;
    grst_pre_d = grst_pre_q;
    core_pre_d = core_pre_q;
    inflight_d = inflight_q;
    ack_d      = '0;
    for (int h = 0; h < NumHarts; h++) begin
      soft_cnt_d[h] = soft_cnt_q[h];
    end
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
    slot_ptr_d = slot_ptr_q;
    stag_cnt_d = stag_cnt_q;
`endif

    // Wake-done edge: freeze the enable mask and let the tile out of reset.
    if (wake_done) begin
      mask_d     = bus.hart_mask_i;
      grst_pre_d = 1'b1;
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
      // Slot 0 coincides with the wake-done edge.
      core_pre_d[0] = bus.hart_mask_i[0];
      slot_ptr_d    = '0;
      stag_cnt_d    = '0;
`else
      core_pre_d    = bus.hart_mask_i;
`endif
    end

`ifdef LAGARTO_RST_SEQ_STAGGER_EN
    // Each slot elapses even for a masked-out hart, which simply stays in reset.
    if (state_q == ST_RELEASE) begin
      if (slot_adv) begin
        stag_cnt_d = '0;
        slot_ptr_d = slot_ptr_nxt;
        for (int h = 0; h < NumHarts; h++) begin
          if (slot_ptr_nxt == PtrW'(h)) begin
            core_pre_d[h] = mask_q[h];
          end
        end
      end else begin
        stag_cnt_d = stag_cnt_q + StagCntW'(1);
      end
    end
`endif

    // Soft reset: hold the hart low for SoftRstCycles edges, then ack when the
    // rising edge emerges from the last synchronizer stage.
    for (int h = 0; h < NumHarts; h++) begin
      if (inflight_q[h]) begin
        if (!mask_q[h]) begin
          // Disabled hart: nothing to reset, acknowledge straight away.
          ack_d[h]      = 1'b1;
          inflight_d[h] = 1'b0;
        end else if (!core_pre_q[h]) begin
          if (soft_cnt_q[h] == SoftCntW'(SoftRstCycles)) begin
            core_pre_d[h] = 1'b1;
          end else begin
            soft_cnt_d[h] = soft_cnt_q[h] + SoftCntW'(1);
          end
        end else if (stage_in_last[h] && !sync_last[h]) begin
          ack_d[h]      = 1'b1;
          inflight_d[h] = 1'b0;
        end
      end else if (state_q == ST_RUN && bus.soft_rst_req_i[h]) begin
        // Requests raised before RUN are levels and are picked up here.
        inflight_d[h] = 1'b1;
        if (mask_q[h]) begin
          core_pre_d[h] = 1'b0;
          soft_cnt_d[h] = SoftCntW'(1);
        end
      end
    end
  end

  // Synchronizer chain inputs and the "everything has propagated" indication.
  always_comb begin
    pre_vec   = {grst_pre_q, core_pre_q};
    sync_d[0] = pre_vec;
    for (int k = 1; k < SyncStages; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    stage_in_last = sync_d[SyncStages-1];
    sync_last     = sync_q[SyncStages-1];
    settled       = 1'b1;
    for (int k = 0; k < SyncStages; k++) begin
      if (sync_q[k] != pre_vec) begin
        settled = 1'b0;
      end
    end
    busy = !((state_q == ST_RUN) && (inflight_q == '0) && settled);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_l) begin
      state_q <= ST_WAKE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, mask, pre-sync resets and handshake state.
  always_ff @(posedge clk_i) begin
    if (!reset_l) begin
      wake_cnt_q <= '0;
      mask_q     <= '0;
      grst_pre_q <= 1'b0;
      core_pre_q <= '0;
      inflight_q <= '0;
      ack_q      <= '0;
      for (int h = 0; h < NumHarts; h++) begin
        soft_cnt_q[h] <= '0;
      end
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
      slot_ptr_q <= '0;
      stag_cnt_q <= '0;
`endif
    end else begin
      wake_cnt_q <= wake_cnt_d;
      mask_q     <= mask_d;
      grst_pre_q <= grst_pre_d;
      core_pre_q <= core_pre_d;
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
      for (int h = 0; h < NumHarts; h++) begin
        soft_cnt_q[h] <= soft_cnt_d[h];
      end
`ifdef LAGARTO_RST_SEQ_STAGGER_EN
      slot_ptr_q <= slot_ptr_d;
      stag_cnt_q <= stag_cnt_d;
`endif
    end
  end

  // Output synchronizer stages; cleared together with everything else.
  always_ff @(posedge clk_i) begin
    if (!reset_l) begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign bus.spc_grst_l     = sync_last[NumHarts];
  assign bus.core_rst_no    = sync_last[NumHarts-1:0];
  assign bus.soft_rst_ack_o = ack_q;
  assign bus.busy_o         = busy;

endmodule
